axi_lite_slave_regs: RTL

AXI-Lite responder that terminates single-beat read and write transactions into a bank of 32-bit read/write registers. It is the far end of the AXI-Lite master bus: the master's AW/W/B/AR/R channels connect directly to it, and the register contents are exported to user logic. Write and read paths are independent and can run concurrently.

---
 rtl/axi_lite_slave_regs.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite responder terminating single-beat reads/writes into NUM_REGS 32-bit registers.
// Define AXI_LITE_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi_lite_slave_regs #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               i_awid,
   input  logic [ADDR_WIDTH-1:0]    i_awaddr,
   input  logic                     i_awvalid,
   output logic                     o_awready,
   input  logic [3:0]               i_wid,
   input  logic [31:0]              i_wdata,
   input  logic [3:0]               i_wstrobe,
   input  logic                     i_wvalid,
   output logic                     o_wready,
   output logic [3:0]               o_bid,
   output logic [1:0]               o_bresp,
   output logic                     o_bvalid,
   input  logic                     i_bready,
   input  logic [3:0]               i_arid,
   input  logic [ADDR_WIDTH-1:0]    i_araddr,
   input  logic                     i_arvalid,
   output logic                     o_arready,
   output logic [3:0]               o_rid,
   output logic [31:0]              o_rdata,
   output logic [1:0]               o_rresp,
   output logic                     o_rlast,
   output logic                     o_rvalid,
   input  logic                     i_rready,
   output logic [NUM_REGS*32-1:0]   o_regs,
   output logic [NUM_REGS-1:0]      o_wr_stb
);
   localparam int IW = ADDR_WIDTH - 2;
`ifdef AXI_LITE_SLAVE_DECERR_EN
   localparam logic DECERR_EN = 1'b1;
`else
   localparam logic DECERR_EN = 1'b0;
`endif

   typedef enum logic {W_ACCEPT, W_RESP} wstate_t;
   typedef enum logic {R_ACCEPT, R_RESP} rstate_t;

   wstate_t        wstate, wstate_nxt;
   rstate_t        rstate, rstate_nxt;
   logic           aw_done, w_done;
   logic [IW-1:0]  aw_idx_cap;
   logic [3:0]     awid_cap;
   logic [31:0]    wdata_cap;
   logic [3:0]     wstrb_cap;
   logic [31:0]    regs [NUM_REGS];
   logic           aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
   logic [IW-1:0]  wr_idx, rd_idx;
   logic [3:0]     wr_id, wr_strb;
   logic [31:0]    wr_data, rd_val;
   logic           wr_hit, rd_hit;
   logic           unused;

   function automatic logic [1:0] resp_for(input logic hit);
      return {2{~hit & DECERR_EN}};
   endfunction

   assign unused  = ^{i_wid, i_awaddr[1:0], i_araddr[1:0]};

   assign aw_hs   = i_awvalid & o_awready;
   assign w_hs    = i_wvalid & o_wready;
   assign ar_hs   = i_arvalid & o_arready;
   assign b_hs    = i_bready & o_bvalid;
   assign r_hs    = i_rready & o_rvalid;
   assign commit  = (wstate == W_ACCEPT) & (aw_done | aw_hs) & (w_done | w_hs);

   // The second half of a write may arrive live while the first is already captured
   assign wr_idx  = aw_done ? aw_idx_cap : i_awaddr[ADDR_WIDTH-1:2];
   assign wr_id   = aw_done ? awid_cap   : i_awid;
   assign wr_data = w_done  ? wdata_cap  : i_wdata;
   assign wr_strb = w_done  ? wstrb_cap  : i_wstrobe;
   assign wr_hit  = wr_idx < IW'(NUM_REGS);
   assign rd_idx  = i_araddr[ADDR_WIDTH-1:2];
   assign rd_hit  = rd_idx < IW'(NUM_REGS);

   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (rd_idx == IW'(k)) rd_val = regs[k];
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
      assign o_regs[32*g +: 32] = regs[g];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wstate <= W_ACCEPT;
         rstate <= R_ACCEPT;
      end else begin
         wstate <= wstate_nxt;
         rstate <= rstate_nxt;
      end
   end

   always_comb begin
      wstate_nxt = wstate;
      rstate_nxt = rstate;
      case (wstate)
         W_ACCEPT: if (commit) wstate_nxt = W_RESP;
         W_RESP:   if (b_hs)   wstate_nxt = W_ACCEPT;
         default:  wstate_nxt = W_ACCEPT;
      endcase
      case (rstate)
         R_ACCEPT: if (ar_hs) rstate_nxt = R_RESP;
         R_RESP:   if (r_hs)  rstate_nxt = R_ACCEPT;
         default:  rstate_nxt = R_ACCEPT;
      endcase
   end

   always_comb begin
      o_awready = (wstate == W_ACCEPT) & ~aw_done;
      o_wready  = (wstate == W_ACCEPT) & ~w_done;
      o_bvalid  = (wstate == W_RESP);
      o_arready = (rstate == R_ACCEPT);
      o_rvalid  = (rstate == R_RESP);
      o_rlast   = (rstate == R_RESP);
   end

   always_ff @(posedge clk) begin
      if (aw_hs) begin
         aw_idx_cap <= i_awaddr[ADDR_WIDTH-1:2];
         awid_cap   <= i_awid;
      end
      if (w_hs) begin
         wdata_cap <= i_wdata;
         wstrb_cap <= i_wstrobe;
      end
   end

   // Write side: channel tracking, B response and the register bank itself
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         o_bid    <= '0;
         o_bresp  <= '0;
         o_wr_stb <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      end else begin
         o_wr_stb <= '0;
         if (commit) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            o_bid   <= wr_id;
            o_bresp <= resp_for(wr_hit);
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
         end
         for (int k = 0; k < NUM_REGS; k++) begin
            if (commit && wr_idx == IW'(k)) begin
               o_wr_stb[k] <= 1'b1;
               for (int n = 0; n < 4; n++)
                  if (wr_strb[n]) regs[k][8*n +: 8] <= wr_data[8*n +: 8];
            end
         end
      end
   end

   // Read side samples the bank before any same-edge write lands
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_rid   <= '0;
         o_rdata <= '0;
         o_rresp <= '0;
      end else if (ar_hs) begin
         o_rid   <= i_arid;
         o_rdata <= rd_val;
         o_rresp <= resp_for(rd_hit);
      end
   end
endmodule
